// File: rtl/memory_game_ctrl.sv
// Memory-card game sequencer for a 4x4 board.
// Moves the cursor, flips cards on picks, compares pairs, and hides a
// mismatched pair after it has been shown for REVEAL_TICKS cycles.
module memory_game_ctrl #(
    parameter int unsigned REVEAL_TICKS = 50_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_sel,
    input  logic [47:0] layout,
    output logic [3:0]  cursor,
    output logic [15:0] face_up,
    output logic [15:0] matched,
    output logic [3:0]  pairs_found,
    output logic [7:0]  moves,
    output logic        busy,
    output logic        game_over
);

    localparam int unsigned TimerW = $clog2(REVEAL_TICKS + 1);

    typedef enum logic [2:0] {StPick1, StPick2, StCompare, StReveal, StDone} state_e;

    state_e              state_q, state_d;
    logic [TimerW-1:0]   timer_q;
    logic [3:0]          first_q, second_q;
    logic [3:0]          cursor_next;
    logic [5:0]          first_base, second_base;
    logic                pick_ok, ids_equal, reveal_end, last_pair;

    // Picks are only accepted while waiting for a card and only on hidden cards.
    assign pick_ok     = btn_sel && !face_up[cursor] && !matched[cursor] &&
                         (state_q == StPick1 || state_q == StPick2);
    assign first_base  = 6'(first_q) * 6'd3;
    assign second_base = 6'(second_q) * 6'd3;
    assign ids_equal   = layout[first_base +: 3] == layout[second_base +: 3];
    assign reveal_end  = (state_q == StReveal) && (timer_q == TimerW'(REVEAL_TICKS - 1));
    assign last_pair   = pairs_found == 4'd7;

    // Cursor move with up > down > left > right priority, row/col wrap independently.
    always_comb begin
        cursor_next = cursor;
        if (btn_up) begin
            cursor_next[3:2] = cursor[3:2] - 2'd1;
        end else if (btn_down) begin
            cursor_next[3:2] = cursor[3:2] + 2'd1;
        end else if (btn_left) begin
            cursor_next[1:0] = cursor[1:0] - 2'd1;
        end else if (btn_right) begin
            cursor_next[1:0] = cursor[1:0] + 2'd1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StPick1;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StPick1:   if (pick_ok) state_d = StPick2;
            StPick2:   if (pick_ok) state_d = StCompare;
            StCompare: begin
                if (ids_equal) begin
                    state_d = last_pair ? StDone : StPick1;
                end else begin
                    state_d = StReveal;
                end
            end
            StReveal:  if (reveal_end) state_d = StPick1;
            StDone:    if (btn_sel) state_d = StPick1;
            default:   state_d = StPick1;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        busy      = (state_q == StCompare) || (state_q == StReveal);
        game_over = (state_q == StDone);
    end

    // Board, cursor, counters and reveal timer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cursor      <= 4'd0;
            face_up     <= 16'd0;
            matched     <= 16'd0;
            pairs_found <= 4'd0;
            moves       <= 8'd0;
            timer_q     <= '0;
            first_q     <= 4'd0;
            second_q    <= 4'd0;
        end else begin
            if (state_q != StDone) begin
                cursor <= cursor_next;
            end
            case (state_q)
                StPick1: begin
                    if (pick_ok) begin
                        face_up[cursor] <= 1'b1;
                        first_q         <= cursor;
                    end
                end
                StPick2: begin
                    if (pick_ok) begin
                        face_up[cursor] <= 1'b1;
                        second_q        <= cursor;
                        if (moves != 8'hFF) begin
                            moves <= moves + 8'd1;
                        end
                    end
                end
                StCompare: begin
                    if (ids_equal) begin
                        matched[first_q]  <= 1'b1;
                        matched[second_q] <= 1'b1;
                        pairs_found       <= pairs_found + 4'd1;
                    end else begin
                        timer_q <= '0;
                    end
                end
                StReveal: begin
                    if (reveal_end) begin
                        face_up[first_q]  <= 1'b0;
                        face_up[second_q] <= 1'b0;
                        timer_q           <= '0;
                    end else begin
                        timer_q <= timer_q + TimerW'(1);
                    end
                end
                StDone: begin
                    // Restart: board is wiped and the cursor returns home.
                    if (btn_sel) begin
                        face_up     <= 16'd0;
                        matched     <= 16'd0;
                        pairs_found <= 4'd0;
                        moves       <= 8'd0;
                        cursor      <= 4'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_game_ctrl.sv
// Self-checking bench for memory_game_ctrl with REVEAL_TICKS=4 and
// layout id(i)=i>>1, so cards 2k and 2k+1 form a pair.
module tb_memory_game_ctrl;

    localparam int unsigned Ticks = 4;

    localparam logic [4:0] BN = 5'b00000;
    localparam logic [4:0] BU = 5'b10000;
    localparam logic [4:0] BD = 5'b01000;
    localparam logic [4:0] BL = 5'b00100;
    localparam logic [4:0] BR = 5'b00010;
    localparam logic [4:0] BS = 5'b00001;

    typedef struct {
        logic [3:0]  cursor;
        logic [15:0] face_up;
        logic [15:0] matched;
        logic [3:0]  pairs;
        logic [7:0]  moves;
        logic        busy;
        logic        game_over;
    } exp_t;

    typedef struct {
        logic [4:0] btn;
        exp_t       e;
    } vec_t;

    logic        clk, rst_n;
    logic        btn_up, btn_down, btn_left, btn_right, btn_sel;
    logic [47:0] layout;
    logic [3:0]  cursor;
    logic [15:0] face_up, matched;
    logic [3:0]  pairs_found;
    logic [7:0]  moves;
    logic        busy, game_over;

    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];
    vec_t tbl[$];
    exp_t ex;
    exp_t zero_e;

    memory_game_ctrl #(.REVEAL_TICKS(Ticks)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .btn_sel     (btn_sel),
        .layout      (layout),
        .cursor      (cursor),
        .face_up     (face_up),
        .matched     (matched),
        .pairs_found (pairs_found),
        .moves       (moves),
        .busy        (busy),
        .game_over   (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [4:0] b, input logic [3:0] c, input logic [15:0] f,
                                input logic [15:0] m, input logic [3:0] p, input logic [7:0] mv,
                                input logic bz, input logic go);
        vec_t v;
        v.btn         = b;
        v.e.cursor    = c;
        v.e.face_up   = f;
        v.e.matched   = m;
        v.e.pairs     = p;
        v.e.moves     = mv;
        v.e.busy      = bz;
        v.e.game_over = go;
        return v;
    endfunction

    // Drive one cycle of buttons, queue the expectation, compare after the edge.
    task automatic apply(input string name, input logic [4:0] b, input exp_t e);
        exp_t want;
        sb_q.push_back(e);
        {btn_up, btn_down, btn_left, btn_right, btn_sel} = b;
        @(posedge clk);
        #1;
        {btn_up, btn_down, btn_left, btn_right, btn_sel} = 5'b0;
        total++;
        if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            want = sb_q.pop_front();
            if (cursor !== want.cursor || face_up !== want.face_up ||
                matched !== want.matched || pairs_found !== want.pairs ||
                moves !== want.moves || busy !== want.busy ||
                game_over !== want.game_over) begin
                bad++;
                $display("FAIL %s: got cur=%0d fu=%h m=%h p=%0d mv=%0d b=%b go=%b want cur=%0d fu=%h m=%h p=%0d mv=%0d b=%b go=%b",
                         name, cursor, face_up, matched, pairs_found, moves, busy, game_over,
                         want.cursor, want.face_up, want.matched, want.pairs, want.moves,
                         want.busy, want.game_over);
            end
        end
    endtask

    // Walk the cursor down then right to a target square, checking every step.
    task automatic move_to(input logic [3:0] target);
        for (int i = 0; i < 4 && ex.cursor[3:2] != target[3:2]; i++) begin
            ex.cursor[3:2] = ex.cursor[3:2] + 2'd1;
            apply("move_down", BD, ex);
        end
        for (int i = 0; i < 4 && ex.cursor[1:0] != target[1:0]; i++) begin
            ex.cursor[1:0] = ex.cursor[1:0] + 2'd1;
            apply("move_right", BR, ex);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            layout[3*i +: 3] = 3'(i >> 1);
        end
        zero_e = mk(BN, 4'd0, 16'h0, 16'h0, 4'd0, 8'd0, 1'b0, 1'b0).e;
        {btn_up, btn_down, btn_left, btn_right, btn_sel} = 5'b0;

        // Test 1: cursor moves, wrap, priority
        tbl.push_back(mk(BR, 4'd1, 16'h0, 16'h0, 4'd0, 8'd0, 1'b0, 1'b0));
        tbl.push_back(mk(BR, 4'd2, 16'h0, 16'h0, 4'd0, 8'd0, 1'b0, 1'b0));
        tbl.push_back(mk(BR, 4'd3, 16'h0, 16'h0, 4'd0, 8'd0, 1'b0, 1'b0));
        tbl.push_back(mk(BR, 4'd0, 16'h0, 16'h0, 4'd0, 8'd0, 1'b0, 1'b0));
        tbl.push_back(mk(BR, 4'd1, 16'h0, 16'h0, 4'd0, 8'd0, 1'b0, 1'b0));
        tbl.push_back(mk(BL, 4'd0, 16'h0, 16'h0, 4'd0, 8'd0, 1'b0, 1'b0));
        tbl.push_back(mk(BL, 4'd3, 16'h0, 16'h0, 4'd0, 8'd0, 1'b0, 1'b0));
        tbl.push_back(mk(BD, 4'd7, 16'h0, 16'h0, 4'd0, 8'd0, 1'b0, 1'b0));
        tbl.push_back(mk(BD, 4'd11, 16'h0, 16'h0, 4'd0, 8'd0, 1'b0, 1'b0));
        tbl.push_back(mk(BD, 4'd15, 16'h0, 16'h0, 4'd0, 8'd0, 1'b0, 1'b0));
        tbl.push_back(mk(BD, 4'd3, 16'h0, 16'h0, 4'd0, 8'd0, 1'b0, 1'b0));
        tbl.push_back(mk(BU, 4'd15, 16'h0, 16'h0, 4'd0, 8'd0, 1'b0, 1'b0));
        tbl.push_back(mk(BD | BR, 4'd3, 16'h0, 16'h0, 4'd0, 8'd0, 1'b0, 1'b0));
        tbl.push_back(mk(BU | BD, 4'd15, 16'h0, 16'h0, 4'd0, 8'd0, 1'b0, 1'b0));
        tbl.push_back(mk(BL | BR, 4'd14, 16'h0, 16'h0, 4'd0, 8'd0, 1'b0, 1'b0));
        tbl.push_back(mk(BR, 4'd15, 16'h0, 16'h0, 4'd0, 8'd0, 1'b0, 1'b0));
        tbl.push_back(mk(BD, 4'd3, 16'h0, 16'h0, 4'd0, 8'd0, 1'b0, 1'b0));
        tbl.push_back(mk(BR, 4'd0, 16'h0, 16'h0, 4'd0, 8'd0, 1'b0, 1'b0));
        // Test 2: matching pair 0/1
        tbl.push_back(mk(BS, 4'd0, 16'h0001, 16'h0, 4'd0, 8'd0, 1'b0, 1'b0));
        tbl.push_back(mk(BR, 4'd1, 16'h0001, 16'h0, 4'd0, 8'd0, 1'b0, 1'b0));
        tbl.push_back(mk(BS, 4'd1, 16'h0003, 16'h0, 4'd0, 8'd1, 1'b1, 1'b0));
        tbl.push_back(mk(BN, 4'd1, 16'h0003, 16'h3, 4'd1, 8'd1, 1'b0, 1'b0));
        // Test 3: mismatch 2/4, reveal window
        tbl.push_back(mk(BR, 4'd2, 16'h0003, 16'h3, 4'd1, 8'd1, 1'b0, 1'b0));
        tbl.push_back(mk(BS, 4'd2, 16'h0007, 16'h3, 4'd1, 8'd1, 1'b0, 1'b0));
        tbl.push_back(mk(BD, 4'd6, 16'h0007, 16'h3, 4'd1, 8'd1, 1'b0, 1'b0));
        tbl.push_back(mk(BL, 4'd5, 16'h0007, 16'h3, 4'd1, 8'd1, 1'b0, 1'b0));
        tbl.push_back(mk(BL, 4'd4, 16'h0007, 16'h3, 4'd1, 8'd1, 1'b0, 1'b0));
        tbl.push_back(mk(BS, 4'd4, 16'h0017, 16'h3, 4'd1, 8'd2, 1'b1, 1'b0));
        tbl.push_back(mk(BN, 4'd4, 16'h0017, 16'h3, 4'd1, 8'd2, 1'b1, 1'b0));
        // Test 4: cursor still moves in REVEAL, pick there is ignored
        tbl.push_back(mk(BR, 4'd5, 16'h0017, 16'h3, 4'd1, 8'd2, 1'b1, 1'b0));
        tbl.push_back(mk(BS, 4'd5, 16'h0017, 16'h3, 4'd1, 8'd2, 1'b1, 1'b0));
        tbl.push_back(mk(BN, 4'd5, 16'h0017, 16'h3, 4'd1, 8'd2, 1'b1, 1'b0));
        tbl.push_back(mk(BN, 4'd5, 16'h0003, 16'h3, 4'd1, 8'd2, 1'b0, 1'b0));
        tbl.push_back(mk(BU, 4'd1, 16'h0003, 16'h3, 4'd1, 8'd2, 1'b0, 1'b0));
        tbl.push_back(mk(BL, 4'd0, 16'h0003, 16'h3, 4'd1, 8'd2, 1'b0, 1'b0));
        tbl.push_back(mk(BS, 4'd0, 16'h0003, 16'h3, 4'd1, 8'd2, 1'b0, 1'b0));

        // Reset state
        rst_n = 1'b0;
        apply("reset", BN, zero_e);
        apply("reset_hold", BN, zero_e);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply($sformatf("vec%0d", i), tbl[i].btn, tbl[i].e);
        end

        // Test 5: clear the remaining pairs; the pick of matched card 0 above must
        // have left the FSM in PICK1, so card 2 opens a fresh pair.
        ex = tbl[tbl.size() - 1].e;
        for (int k = 1; k < 8; k++) begin
            move_to(4'(2 * k));
            ex.face_up[2*k] = 1'b1;
            apply("pick_a", BS, ex);
            ex.cursor = ex.cursor + 4'd1;
            apply("step_b", BR, ex);
            ex.face_up[2*k+1] = 1'b1;
            ex.moves = ex.moves + 8'd1;
            ex.busy = 1'b1;
            apply("pick_b", BS, ex);
            ex.busy = 1'b0;
            ex.matched[2*k] = 1'b1;
            ex.matched[2*k+1] = 1'b1;
            ex.pairs = ex.pairs + 4'd1;
            ex.game_over = (ex.pairs == 4'd8);
            apply("pair_done", BN, ex);
        end
        apply("done_cursor_frozen", BR, ex);
        apply("restart", BS, zero_e);

        // Test 6: reset in the middle of REVEAL, then up+sel same cycle
        ex = zero_e;
        ex.face_up = 16'h0001;
        apply("t6_pick0", BS, ex);
        ex.cursor = 4'd1;
        apply("t6_r1", BR, ex);
        ex.cursor = 4'd2;
        apply("t6_r2", BR, ex);
        ex.face_up = 16'h0005;
        ex.moves = 8'd1;
        ex.busy = 1'b1;
        apply("t6_pick2", BS, ex);
        apply("t6_reveal0", BN, ex);
        apply("t6_reveal1", BN, ex);
        rst_n = 1'b0;
        apply("t6_reset", BS, zero_e);
        rst_n = 1'b1;
        ex = zero_e;
        ex.cursor = 4'd4;
        apply("t6_down", BD, ex);
        ex.cursor = 4'd5;
        apply("t6_right", BR, ex);
        ex.cursor = 4'd1;
        ex.face_up = 16'h0020;
        apply("t6_up_sel", BU | BS, ex);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
